// File: rtl/mul_pkg.sv
// Shared constants and product type for the bit-serial multiplier slice.
// The border cell and the partial-product accumulator both use these definitions.
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_DEPTH = 4;

  typedef logic signed [2*MUL_WIDTH-1:0] mul_prod_t;

endpackage

// File: rtl/mul_pp_acc_if.sv
// Bus between the partial-product accumulator and its neighbours: the border cell feed
// and clear going in, the product valid/ready register and status flags coming out.
interface mul_pp_acc_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic                      clr;
  logic signed [2*WIDTH-1:0] i_pp;
  logic                      i_ready;
  logic signed [2*WIDTH-1:0] o_data;
  logic                      o_valid;
  logic                      o_busy;
  logic                      o_drop;

  modport master (
    input  clr,
    input  i_pp,
    input  i_ready,
    output o_data,
    output o_valid,
    output o_busy,
    output o_drop
  );

  modport slave (
    output clr,
    output i_pp,
    output i_ready,
    input  o_data,
    input  o_valid,
    input  o_busy,
    input  o_drop
  );

endinterface

// File: rtl/mul_pp_acc_term.sv
// Weights one partial product by its bit position; the multiplier MSB carries a
// negative weight in two's complement, so its term is negated.
module mul_pp_term
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int DEPTH = MUL_DEPTH
) (
  input  logic signed [2*WIDTH-1:0] pp,
  input  logic        [DEPTH-1:0]   cnt,
  input  logic                      is_msb,
  output logic signed [2*WIDTH-1:0] term
);

  logic signed [2*WIDTH-1:0] shifted;

  assign shifted = pp <<< cnt;
  assign term    = is_msb ? -shifted : shifted;

endmodule

// File: rtl/mul_pp_acc.sv
// Shift-add accumulator behind the serial border cell: WIDTH partial products in, one
// signed product out through a 1-deep valid/ready register (overwrite sets sticky o_drop).
module mul_pp_acc
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int DEPTH = MUL_DEPTH
) (
  input logic          clk,
  input logic          rst_n,
  mul_pp_acc_if.master bus
);

  localparam logic [DEPTH-1:0] CNT_LAST = DEPTH'(WIDTH - 1);

  logic        [DEPTH-1:0]   cnt;
  logic signed [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] acc_next;
  logic signed [2*WIDTH-1:0] term;
  logic signed [2*WIDTH-1:0] data_q;
  logic                      valid_q;
  logic                      drop_q;
  logic                      is_last;

  assign is_last = (cnt == CNT_LAST);

  mul_pp_term #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_term (
    .pp     (bus.i_pp),
    .cnt    (cnt),
    .is_msb (is_last),
    .term   (term)
  );

  assign acc_next = acc + term;

  // The counter free-runs with no enable so it stays in lockstep with the border cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else if (bus.clr) begin
      cnt     <= '0;
      acc     <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (is_last) begin
        acc     <= '0;
        data_q  <= acc_next;
        valid_q <= 1'b1;
        if (valid_q && !bus.i_ready) begin
          drop_q <= 1'b1;
        end
      end else begin
        acc <= acc_next;
        if (valid_q && bus.i_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_drop  = drop_q;
  assign bus.o_busy  = (cnt != '0);

endmodule

// File: tb/tb_mul_pp_acc.sv
// Directed bench for mul_pp_acc: feeds border-cell partial products for hand-picked
// operand pairs and compares the product register and flags against hand-computed values.
module tb_mul_pp_acc;
  import mul_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mul_pp_acc_if #(.WIDTH(MUL_WIDTH)) bus ();

  mul_pp_acc #(
    .WIDTH (MUL_WIDTH),
    .DEPTH (MUL_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Border-cell equivalent: bit k of a selects sign-extended b, else zero.
  task automatic run_bits(input logic [15:0] a, input logic [15:0] b, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      bus.i_pp = a[k] ? mul_prod_t'({{16{b[15]}}, b}) : '0;
      @(posedge clk);
      #1;
    end
    bus.i_pp = '0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b1;
    bus.clr     = 1'b0;
    bus.i_pp    = '0;
    bus.i_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data",  bus.o_data, 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_busy",  32'(bus.o_busy), 32'h0);
    chk("rst_drop",  32'(bus.o_drop), 32'h0);
    #14 rst_n = 1'b1;

    // 3*5, ready high
    run_bits(16'd3, 16'd5, 0, 0);
    chk("t1_busy_mid", 32'(bus.o_busy), 32'h1);
    run_bits(16'd3, 16'd5, 1, 14);
    chk("t1_valid_early", 32'(bus.o_valid), 32'h0);
    run_bits(16'd3, 16'd5, 15, 15);
    chk("t1_valid", 32'(bus.o_valid), 32'h1);
    chk("t1_data",  bus.o_data, 32'd15);
    chk("t1_drop",  32'(bus.o_drop), 32'h0);
    chk("t1_busy_end", 32'(bus.o_busy), 32'h0);
    @(posedge clk); #1;
    chk("t1_valid_fall", 32'(bus.o_valid), 32'h0);

    // -1*-1 exercises the MSB subtraction
    pulse_clr();
    run_bits(16'hFFFF, 16'hFFFF, 0, 15);
    chk("t2_data", bus.o_data, 32'h0000_0001);

    // extremes
    run_bits(16'h8000, 16'h8000, 0, 15);
    chk("t3_minmin", bus.o_data, 32'h4000_0000);
    run_bits(16'd7, 16'hFFFE, 0, 15);
    chk("t3_7xm2", bus.o_data, 32'hFFFF_FFF2);
    chk("t3_drop", 32'(bus.o_drop), 32'h0);

    // back-to-back under backpressure: 2*3 then 4*5
    pulse_clr();
    bus.i_ready = 1'b0;
    run_bits(16'd2, 16'd3, 0, 15);
    chk("t4_first", bus.o_data, 32'd6);
    chk("t4_drop0", 32'(bus.o_drop), 32'h0);
    run_bits(16'd4, 16'd5, 0, 7);
    chk("t4_hold", bus.o_data, 32'd6);
    run_bits(16'd4, 16'd5, 8, 15);
    chk("t4_second", bus.o_data, 32'd20);
    chk("t4_valid",  32'(bus.o_valid), 32'h1);
    chk("t4_drop1",  32'(bus.o_drop), 32'h1);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_valid_fall", 32'(bus.o_valid), 32'h0);
    chk("t4_drop_sticky", 32'(bus.o_drop), 32'h1);

    // clr mid-operation with a pending product and a set drop flag
    pulse_clr();
    chk("t5_clr_drop", 32'(bus.o_drop), 32'h0);
    bus.i_ready = 1'b0;
    run_bits(16'd1, 16'd1, 0, 15);
    run_bits(16'd1, 16'd1, 0, 15);
    chk("t5_pre_drop", 32'(bus.o_drop), 32'h1);
    run_bits(16'd6, 16'd6, 0, 6);
    chk("t5_busy", 32'(bus.o_busy), 32'h1);
    pulse_clr();
    chk("t5_valid", 32'(bus.o_valid), 32'h0);
    chk("t5_drop",  32'(bus.o_drop), 32'h0);
    chk("t5_cnt0",  32'(bus.o_busy), 32'h0);
    chk("t5_data_kept", bus.o_data, 32'd1);
    bus.i_ready = 1'b1;
    run_bits(16'd6, 16'd6, 0, 15);
    chk("t5_realign", bus.o_data, 32'd36);
    chk("t5_valid2",  32'(bus.o_valid), 32'h1);

    // async reset between clock edges, mid-operation
    run_bits(16'd3, 16'd5, 0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_data",  bus.o_data, 32'h0);
    chk("t6_valid", 32'(bus.o_valid), 32'h0);
    chk("t6_busy",  32'(bus.o_busy), 32'h0);
    chk("t6_drop",  32'(bus.o_drop), 32'h0);
    #1 rst_n = 1'b1;
    run_bits(16'hFFFD, 16'd9, 0, 15);
    chk("t6_after", bus.o_data, 32'hFFFF_FFE5);
    chk("t6_valid2", 32'(bus.o_valid), 32'h1);
    @(posedge clk); #1;
    chk("t6_taken", 32'(bus.o_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
